// File: rtl/vector_mem_pkg.sv
// Shared types and default sizing for the vector load/store unit and its byte RAM.
package vector_mem_pkg;

    localparam int LANES          = 16;
    localparam int ELEM_W         = 16;
    localparam int ADDR_W         = 16;
    localparam int DEPTH_BYTES    = 256;
    localparam int BYTES_PER_ELEM = ELEM_W / 8;

    typedef logic [LANES-1:0][ELEM_W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/byte_ram.sv
// Byte-wide scratch storage: one element (NBYTES consecutive bytes, little-endian)
// written synchronously and read asynchronously per access.
module byte_ram #(
    parameter int DEPTH_BYTES = 256,
    parameter int NBYTES      = 2,
    parameter int RA_W        = $clog2(DEPTH_BYTES)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [RA_W-1:0]       addr,
    input  logic [8*NBYTES-1:0]   wdata,
    output logic [8*NBYTES-1:0]   rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    // Asynchronous element read; bytes beyond the array read as zero.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NBYTES; k++) begin
            if (({1'b0, addr} + (RA_W+1)'(k)) < (RA_W+1)'(DEPTH_BYTES)) begin
                rdata[8*k +: 8] = mem[RA_W'(addr + RA_W'(k))];
            end
        end
    end

    // Synchronous element write, low byte at addr; storage is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (({1'b0, addr} + (RA_W+1)'(k)) < (RA_W+1)'(DEPTH_BYTES)) begin
                    mem[RA_W'(addr + RA_W'(k))] <= wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/vector_data_mem_lsu.sv
// Vector load/store unit: accepts one strided, masked vector request, walks the
// lanes one per cycle against a byte RAM, then holds the response until taken.
module vector_data_mem_lsu #(
    parameter int LANES       = vector_mem_pkg::LANES,
    parameter int ELEM_W      = vector_mem_pkg::ELEM_W,
    parameter int ADDR_W      = vector_mem_pkg::ADDR_W,
    parameter int DEPTH_BYTES = vector_mem_pkg::DEPTH_BYTES
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [ADDR_W-1:0]              req_base,
    input  logic [ADDR_W-1:0]              req_stride,
    input  logic [LANES-1:0]               req_lane_mask,
    input  logic [LANES-1:0][ELEM_W-1:0]   req_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [LANES-1:0][ELEM_W-1:0]   rsp_rdata,
    output logic [LANES-1:0]               rsp_err_mask
);
    import vector_mem_pkg::*;

    localparam int EBYTES = ELEM_W / 8;
    localparam int LW     = $clog2(LANES);
    localparam int RA_W   = $clog2(DEPTH_BYTES);

    lsu_state_t                   state_q, state_d;
    logic [LW-1:0]                lane_q, lane_d;
    logic                         we_q, we_d;
    logic [ADDR_W-1:0]            base_q, base_d;
    logic [ADDR_W-1:0]            stride_q, stride_d;
    logic [LANES-1:0]             mask_q, mask_d;
    logic [LANES-1:0][ELEM_W-1:0] wdata_q, wdata_d;
    logic [LANES-1:0][ELEM_W-1:0] rdata_q, rdata_d;
    logic [LANES-1:0]             err_q, err_d;

    logic [ADDR_W-1:0]            lane_addr;
    logic [ADDR_W:0]              lane_end;
    logic                         lane_in_range;
    logic                         lane_en;
    logic                         ram_we;
    logic [ELEM_W-1:0]            ram_rdata;

    // Current lane address (wraps mod 2^ADDR_W) and its range check on the last byte.
    always_comb begin
        lane_addr     = base_q + ADDR_W'(lane_q) * stride_q;
        lane_end      = {1'b0, lane_addr} + (ADDR_W+1)'(EBYTES - 1);
        lane_in_range = lane_end < (ADDR_W+1)'(DEPTH_BYTES);
        lane_en       = mask_q[lane_q];
        // Writes are suppressed on the reset edge so an aborted store stops cleanly.
        ram_we        = (state_q == ACCESS) && !RST && we_q && lane_en && lane_in_range;
    end

    byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .NBYTES      (EBYTES),
        .RA_W        (RA_W)
    ) u_ram (
        .clk   (CLK),
        .wr_en (ram_we),
        .addr  (lane_addr[RA_W-1:0]),
        .wdata (wdata_q[lane_q]),
        .rdata (ram_rdata)
    );

    // Sequencer next-state: accept in IDLE, one lane per cycle in ACCESS, hold in RESP.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        we_d     = we_q;
        base_d   = base_q;
        stride_d = stride_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        req_ready = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    base_d   = req_base;
                    stride_d = req_stride;
                    mask_d   = req_lane_mask;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = '0;
                    lane_d   = '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (lane_en) begin
                    if (!lane_in_range) begin
                        err_d[lane_q] = 1'b1;
                    end else if (!we_q) begin
                        rdata_d[lane_q] = ram_rdata;
                    end
                end
                if (lane_q == LW'(LANES - 1)) begin
                    state_d = RESP;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response outputs are only driven while a response is pending.
    always_comb begin
        rsp_valid    = (state_q == RESP);
        rsp_rdata    = rsp_valid ? rdata_q : '0;
        rsp_err_mask = rsp_valid ? err_q : '0;
    end

    // Control state: reset returns to IDLE at lane 0, aborting any request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    // Request and result buffers; cleared on accept rather than on reset.
    always_ff @(posedge CLK) begin
        we_q     <= we_d;
        base_q   <= base_d;
        stride_q <= stride_d;
        mask_q   <= mask_d;
        wdata_q  <= wdata_d;
        rdata_q  <= rdata_d;
        err_q    <= err_d;
    end

endmodule

// File: tb/tb_vector_data_mem_lsu.sv
// Directed bench for vector_data_mem_lsu: a table of requests with hand-computed
// responses, plus backpressure and mid-store reset sequences.
module tb_vector_data_mem_lsu;
    import vector_mem_pkg::*;

    localparam int VW = LANES * ELEM_W;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDR_W-1:0]    req_base;
    logic [ADDR_W-1:0]    req_stride;
    logic [LANES-1:0]     req_lane_mask;
    vec_t                 req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    vec_t                 rsp_rdata;
    logic [LANES-1:0]     rsp_err_mask;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    vector_data_mem_lsu dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_base      (req_base),
        .req_stride    (req_stride),
        .req_lane_mask (req_lane_mask),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err_mask  (rsp_err_mask)
    );

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] stride;
        logic [LANES-1:0]  mask;
        vec_t              wdata;
        vec_t              exp_rdata;
        logic [LANES-1:0]  exp_err;
    } rec_t;

    localparam int NREC = 16;
    rec_t tbl [NREC];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t seqv(input int start, input int step);
        vec_t v;
        for (int i = 0; i < LANES; i++) v[i] = ELEM_W'(start + i * step);
        return v;
    endfunction

    function automatic rec_t mk(input logic we, input logic [ADDR_W-1:0] base,
                                input logic [ADDR_W-1:0] stride, input logic [LANES-1:0] mask,
                                input vec_t wd, input vec_t erd, input logic [LANES-1:0] eerr);
        rec_t r;
        r.we = we; r.base = base; r.stride = stride; r.mask = mask;
        r.wdata = wd; r.exp_rdata = erd; r.exp_err = eerr;
        return r;
    endfunction

    task automatic issue(input logic we, input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                         input logic [LANES-1:0] mask, input vec_t wd);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_before_issue", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_base = base; req_stride = stride;
        req_lane_mask = mask; req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    // Counts cycles from the accept cycle until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t zero, mix, low4, oor, unal, wrap1;
        int   lat;
        int   seen;

        zero = '0;
        mix  = seqv(16'h00A0, 1);
        for (int i = 0; i < 8; i++) mix[i] = 16'h5555;
        low4 = '0;
        for (int i = 0; i < 4; i++) low4[i] = 16'h5555;
        oor = '0;
        for (int i = 0; i < 4; i++) oor[i] = ELEM_W'(16'h1100 + i);
        unal = '0;
        unal[0] = 16'h0111; unal[1] = 16'h0211; unal[2] = 16'h0311;
        wrap1 = '0;
        wrap1[1] = 16'h5555;

        tbl[0]  = mk(1'b1, 16'h0080, 16'd2, 16'hFFFF, zero,               zero,            16'h0000);
        tbl[1]  = mk(1'b1, 16'h0000, 16'd2, 16'hFFFF, seqv(1, 1),         zero,            16'h0000);
        tbl[2]  = mk(1'b0, 16'h0000, 16'd2, 16'hFFFF, zero,               seqv(1, 1),      16'h0000);
        tbl[3]  = mk(1'b1, 16'h0000, 16'd2, 16'hFFFF, seqv(16'h00A0, 1),  zero,            16'h0000);
        tbl[4]  = mk(1'b1, 16'h0000, 16'd2, 16'h00FF, seqv(16'h5555, 0),  zero,            16'h0000);
        tbl[5]  = mk(1'b0, 16'h0000, 16'd2, 16'hFFFF, zero,               mix,             16'h0000);
        tbl[6]  = mk(1'b0, 16'h0000, 16'd2, 16'h000F, zero,               low4,            16'h0000);
        tbl[7]  = mk(1'b1, 16'h0040, 16'd0, 16'hFFFF, seqv(0, 1),         zero,            16'h0000);
        tbl[8]  = mk(1'b0, 16'h0040, 16'd0, 16'hFFFF, zero,               seqv(16'h000F, 0), 16'h0000);
        tbl[9]  = mk(1'b1, 16'h00F8, 16'd2, 16'hFFFF, seqv(16'h1100, 1),  zero,            16'hFFF0);
        tbl[10] = mk(1'b0, 16'h00F8, 16'd2, 16'hFFFF, zero,               oor,             16'hFFF0);
        tbl[11] = mk(1'b0, 16'h0000, 16'd2, 16'hFFFF, zero,               mix,             16'h0000);
        tbl[12] = mk(1'b0, 16'h00F8, 16'd2, 16'h000F, zero,               oor,             16'h0000);
        tbl[13] = mk(1'b0, 16'h00FF, 16'd0, 16'h0001, zero,               zero,            16'h0001);
        tbl[14] = mk(1'b0, 16'h00F9, 16'd2, 16'h0007, zero,               unal,            16'h0000);
        tbl[15] = mk(1'b0, 16'hFFFE, 16'd2, 16'h0003, zero,               wrap1,           16'h0001);

        RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_base = '0; req_stride = '0;
        req_lane_mask = '0; req_wdata = '0; rsp_ready = 1'b0;
        tick(); tick(); tick();
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err",   rsp_err_mask, 0);
        RST = 1'b0;
        tick();
        check("post_reset_req_ready", req_ready, 1);
        check("post_reset_rsp_valid", rsp_valid, 0);

        for (int i = 0; i < NREC; i++) begin
            issue(tbl[i].we, tbl[i].base, tbl[i].stride, tbl[i].mask, tbl[i].wdata);
            wait_rsp(lat);
            check($sformatf("latency[%0d]", i), lat, 17);
            check($sformatf("rdata[%0d]", i), rsp_rdata, tbl[i].exp_rdata);
            check($sformatf("err[%0d]", i), rsp_err_mask, tbl[i].exp_err);
            take_rsp();
        end

        // Backpressure: response held stable, new requests ignored while pending.
        issue(1'b0, 16'h0000, 16'd2, 16'hFFFF, zero);
        wait_rsp(lat);
        check("bp_latency", lat, 17);
        req_valid = 1'b1; req_we = 1'b1; req_base = 16'h0000; req_stride = 16'd2;
        req_lane_mask = 16'hFFFF; req_wdata = seqv(16'hFFFF, 0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_rsp_valid[%0d]", c), rsp_valid, 1);
            check($sformatf("bp_rdata[%0d]", c), rsp_rdata, mix);
            check($sformatf("bp_err[%0d]", c), rsp_err_mask, 0);
            check($sformatf("bp_req_ready[%0d]", c), req_ready, 0);
            tick();
        end
        req_valid = 1'b0;
        check("bp_rdata_final", rsp_rdata, mix);
        take_rsp();
        check("bp_req_ready_after", req_ready, 1);
        check("bp_rsp_valid_after", rsp_valid, 0);
        issue(1'b0, 16'h0000, 16'd2, 16'hFFFF, zero);
        wait_rsp(lat);
        check("bp_ignored_req_rdata", rsp_rdata, mix);
        take_rsp();

        // Reset during a store: lanes 0-4 land, then the request is dropped.
        issue(1'b1, 16'h0080, 16'd2, 16'hFFFF, seqv(16'hBEEF, 0));
        for (int c = 0; c < 5; c++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_abort_req_ready", req_ready, 1);
        check("rst_abort_rsp_valid", rsp_valid, 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("rst_abort_no_rsp", seen, 0);
        issue(1'b0, 16'h0080, 16'd2, 16'hFFFF, zero);
        wait_rsp(lat);
        begin
            vec_t exp_b;
            exp_b = '0;
            for (int i = 0; i < 5; i++) exp_b[i] = 16'hBEEF;
            check("rst_abort_rdata", rsp_rdata, exp_b);
        end
        check("rst_abort_err", rsp_err_mask, 0);
        take_rsp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_data_mem_lsu.md
Name: vector_data_mem_lsu

Overview:
- Parametrised successor to the vector DataMemory: a byte-addressed, little-endian scratch memory with a built-in load/store sequencer.
- Each request is one full vector access: base address, byte stride and a per-lane mask replace the fixed s3..s0 select bits.
- The sequencer performs one lane access per cycle, then returns a response over a valid/ready handshake.
- Sits between the vector register file/execute stage and memory in the vector CPU.

Parameters:
LANES, 16, number of vector lanes (power of two, 2..32)
ELEM_W, 16, element width in bits (8, 16 or 32)
ADDR_W, 16, byte address width
DEPTH_BYTES, 256, memory size in bytes (at most 2^ADDR_W)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
req_valid  in  1  request offered
req_ready  out  1  sequencer can accept a request
req_we  in  1  1 = vector store, 0 = vector load
req_base  in  ADDR_W  byte address of lane 0
req_stride  in  ADDR_W  byte distance between consecutive lanes, unsigned
req_lane_mask  in  LANES  bit i = 1 enables lane i
req_wdata  in  LANES x ELEM_W  store data, packed [LANES-1:0][ELEM_W-1:0]
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  LANES x ELEM_W  load data (all zero for stores)
rsp_err_mask  out  LANES  bit i = lane i was out of range

Behaviour:
- Reset is synchronous and active-high on the single clock CLK, as already decided.
- While RST is high and on the first cycle after it drops: state = IDLE, req_ready = 1 (combinational from state), rsp_valid = 0, rsp_rdata = 0, rsp_err_mask = 0, lane index = 0.
- Memory contents are not reset.
- State machine:
  - IDLE: req_ready = 1. On req_valid && req_ready, latch we, base, stride, mask and wdata; clear the rdata and err buffers; lane index = 0; go to ACCESS.
  - ACCESS: req_ready = 0. Process exactly one lane per cycle, masked or not, so latency is fixed. When lane index = LANES-1, go to RESP.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err_mask are stable. On rsp_ready, go to IDLE. The next request is accepted the cycle after.
- Latency: accept edge at cycle 0, rsp_valid high at cycle LANES+1. With rsp_ready tied high, one request completes every LANES+2 cycles.
- Lane address: addr_i = (base + i*stride) mod 2^ADDR_W, truncated to ADDR_W bits; wrap is legal.
- Range check: a lane is out of range if addr_i + ELEM_W/8 - 1 >= DEPTH_BYTES. Such a lane sets its err bit, performs no write, and returns 0 for a load. Masking takes precedence: a masked lane never sets an err bit.
- Store lane (mask bit 1, in range): write ELEM_W/8 bytes, low byte at addr_i. Lanes are written in ascending order, so on overlapping addresses the highest lane wins.
- Load lane (mask bit 1, in range): read bytes asynchronously and register them into the rdata buffer at lane i. A masked lane reads as 0.
- A store is fully visible to any later request; there is no bypass within a request.
- Reset in ACCESS or RESP aborts the request: no response is issued, and bytes already written stay written.
- req_* inputs are ignored outside IDLE.
- Unaligned addresses are legal; no alignment fault is raised.

Decomposition:
- Package vector_mem_pkg holds:
  - default constants LANES, ELEM_W, ADDR_W, DEPTH_BYTES;
  - derived constant BYTES_PER_ELEM;
  - typedef vec_t (packed LANES x ELEM_W);
  - typedef lsu_state_t enum {IDLE, ACCESS, RESP}.
- One sub-module, byte_ram: DEPTH_BYTES x 8 storage; synchronous write of BYTES_PER_ELEM consecutive bytes with per-element write enable; asynchronous read of BYTES_PER_ELEM consecutive bytes.
- The sequencer FSM, address generation and range check stay in vector_data_mem_lsu.

Test Plan:
- Store then load, base 0x0000, stride 2, mask 0xFFFF, wdata lane i = i+1; then a full-mask load of the same span -> rdata lane i = i+1, err_mask 0x0000, rsp_valid exactly 17 cycles after each accept.
- Masking: fill 0x0000-0x001F with lane i = 0x00A0+i, then store 0x5555 to all lanes with mask 0x00FF -> full-mask load returns 0x5555 in lanes 0-7 and 0x00A8-0x00AF in lanes 8-15; a load with mask 0x000F returns 0 in lanes 4-15.
- Overlap: store stride 0, base 0x0040, wdata lane i = i -> load stride 0 returns 0x000F in every lane.
- Out of range: DEPTH 256, base 0x00F8, stride 2, full-mask store -> err_mask 0xFFF0; bytes 0xF8-0xFF written by lanes 0-3; no write past 0xFF; a load of the same span returns 0 in lanes 4-15.
- Backpressure: hold rsp_ready low 3 cycles after rsp_valid rises -> rsp_valid, rsp_rdata and rsp_err_mask are unchanged and req_ready stays 0; after the handshake, req_ready = 1 the next cycle.
- Reset mid-store: assert RST for 1 cycle after lane 4 of a full-mask store of 0xBEEF at base 0x0080, stride 2 -> no rsp_valid; req_ready = 1 on the cycle after RST drops; a load shows 0xBEEF only in lanes 0-4.
